// File: rtl/soc_bus_pkg.sv
// Shared SoC bus definitions: arbiter state encoding, error read data and
// default arbitration/timeout limits reused by bus slaves and bridges.
package soc_bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY_IF,
    BUSY_LS
  } arb_state_t;

  localparam logic [31:0] ARB_ERR_RDATA = 32'h0;

  localparam int ARB_STARVE_MAX_DEF = 4;
  localparam int ARB_TIMEOUT_DEF    = 255;

endpackage

// File: rtl/arb_timeout_cnt.sv
// Busy-cycle watchdog: counts enabled cycles since the last clear and flags
// the cycle in which the TIMEOUT-th busy cycle is reached.
module arb_timeout_cnt #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rstn,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

  logic [7:0] count;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && count != 8'hFF) begin
      count <= count + 8'd1;
    end
  end

  // count holds the number of busy cycles already completed, so the current
  // busy cycle is the TIMEOUT-th one when count equals TIMEOUT-1
  assign expired = enable && (count == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the fetch and load/store ports:
// one outstanding access, data priority with an instruction starvation guard.
module mem_port_arbiter
  import soc_bus_pkg::*;
#(
  parameter int STARVE_MAX = ARB_STARVE_MAX_DEF,
  parameter int TIMEOUT    = ARB_TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  input  logic        ls_req,
  input  logic [31:0] ls_addr,
  input  logic [3:0]  ls_we,
  input  logic [31:0] ls_wdata,
  output logic [31:0] ls_rdata,
  output logic        ls_ack,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        cpu_wait,
  output logic        bus_err
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  arb_state_t state;
  logic [3:0] streak;
  logic       grant_ls;
  logic       grant_if;
  logic       busy;
  logic       expired;
  logic       done;

  assign busy     = (state != IDLE);
  assign grant_ls = (state == IDLE) && ls_req && (!if_req || streak < STARVE_LIM);
  assign grant_if = (state == IDLE) && if_req && !grant_ls;
  assign done     = busy && (mem_ready || expired);

  arb_timeout_cnt #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .rstn   (rstn),
    .clear  (grant_ls || grant_if),
    .enable (busy),
    .expired(expired)
  );

  // Grant and completion FSM; the memory-side signals are registered on grant
  // and held for the whole access.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= IDLE;
      streak    <= '0;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      mem_we    <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_if || !if_req) begin
            streak <= '0;
          end else if (grant_ls && streak != 4'hF) begin
            streak <= streak + 4'd1;
          end
          if (grant_ls) begin
            state     <= BUSY_LS;
            mem_req   <= 1'b1;
            mem_addr  <= ls_addr;
            mem_we    <= ls_we;
            mem_wdata <= ls_wdata;
          end else if (grant_if) begin
            state     <= BUSY_IF;
            mem_req   <= 1'b1;
            mem_addr  <= if_addr;
            mem_we    <= '0;
            mem_wdata <= '0;
          end
        end
        default: begin
          if (done) begin
            state   <= IDLE;
            mem_req <= 1'b0;
          end
        end
      endcase
    end
  end

  // Completion is reported in the same cycle as mem_ready or the timeout;
  // a timeout returns the error pattern instead of memory data.
  assign if_ack   = rstn && done && (state == BUSY_IF);
  assign ls_ack   = rstn && done && (state == BUSY_LS);
  assign bus_err  = rstn && busy && expired && !mem_ready;
  assign if_rdata = !if_ack ? 32'h0 : (mem_ready ? mem_rdata : ARB_ERR_RDATA);
  assign ls_rdata = !ls_ack ? 32'h0 : (mem_ready ? mem_rdata : ARB_ERR_RDATA);
  assign cpu_wait = (if_req && !if_ack) || (ls_req && !ls_ack);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios with literal
// expectations plus randomized traffic against a transaction-level model.
module tb_mem_port_arbiter;

  localparam int STARVE_MAX = 4;
  localparam int TIMEOUT    = 8;

  logic        clk = 1'b0;
  logic        rstn;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        ls_req;
  logic [31:0] ls_addr;
  logic [3:0]  ls_we;
  logic [31:0] ls_wdata;
  logic [31:0] ls_rdata;
  logic        ls_ack;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [3:0]  mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        cpu_wait;
  logic        bus_err;

  int vectors     = 0;
  int miscompares = 0;

  mem_port_arbiter #(
    .STARVE_MAX(STARVE_MAX),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_rdata (if_rdata),
    .if_ack   (if_ack),
    .ls_req   (ls_req),
    .ls_addr  (ls_addr),
    .ls_we    (ls_we),
    .ls_wdata (ls_wdata),
    .ls_rdata (ls_rdata),
    .ls_ack   (ls_ack),
    .mem_req  (mem_req),
    .mem_addr (mem_addr),
    .mem_we   (mem_we),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready),
    .cpu_wait (cpu_wait),
    .bus_err  (bus_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic ir, input logic [31:0] ia,
                               input logic lr, input logic [31:0] la,
                               input logic [3:0] lw, input logic [31:0] ld,
                               input logic mr, input logic [31:0] md);
    @(posedge clk);
    #1;
    if_req    = ir;
    if_addr   = ia;
    ls_req    = lr;
    ls_addr   = la;
    ls_we     = lw;
    ls_wdata  = ld;
    mem_ready = mr;
    mem_rdata = md;
  endtask

  // Transaction-level model: owner 0 = none, 1 = fetch, 2 = load/store;
  // age = cycles elapsed since the grant; streak = LS grants while IF waited.
  int          m_owner  = 0;
  int          m_age    = 0;
  int          m_streak = 0;
  bit          m_known  = 1'b1;
  logic [31:0] m_addr   = '0;
  logic [3:0]  m_we     = '0;
  logic [31:0] m_wdata  = '0;
  bit          e_busy, e_done, e_tmo, e_if_ack, e_ls_ack, e_err, e_wait;
  logic [31:0] e_if_rdata, e_ls_rdata;

  always @(negedge clk) begin
    e_busy     = (m_owner != 0);
    e_tmo      = e_busy && (m_age == TIMEOUT);
    e_done     = e_busy && (mem_ready || e_tmo);
    e_if_ack   = rstn && e_done && (m_owner == 1);
    e_ls_ack   = rstn && e_done && (m_owner == 2);
    e_err      = rstn && e_tmo && !mem_ready;
    e_if_rdata = (e_if_ack && mem_ready) ? mem_rdata : 32'h0;
    e_ls_rdata = (e_ls_ack && mem_ready) ? mem_rdata : 32'h0;
    e_wait     = (if_req && !e_if_ack) || (ls_req && !e_ls_ack);

    checkOutput("mem_req", {31'd0, mem_req}, {31'd0, e_busy});
    if (e_busy || m_known) begin
      checkOutput("mem_addr", mem_addr, m_addr);
      checkOutput("mem_we", {28'd0, mem_we}, {28'd0, m_we});
      checkOutput("mem_wdata", mem_wdata, m_wdata);
    end
    checkOutput("if_ack", {31'd0, if_ack}, {31'd0, e_if_ack});
    checkOutput("ls_ack", {31'd0, ls_ack}, {31'd0, e_ls_ack});
    checkOutput("if_rdata", if_rdata, e_if_rdata);
    checkOutput("ls_rdata", ls_rdata, e_ls_rdata);
    checkOutput("bus_err", {31'd0, bus_err}, {31'd0, e_err});
    checkOutput("cpu_wait", {31'd0, cpu_wait}, {31'd0, e_wait});

    if (!rstn) begin
      m_owner  = 0;
      m_streak = 0;
      m_known  = 1'b1;
      m_addr   = '0;
      m_we     = '0;
      m_wdata  = '0;
    end else if (m_owner == 0) begin
      if (ls_req && (!if_req || m_streak < STARVE_MAX)) begin
        m_owner  = 2;
        m_addr   = ls_addr;
        m_we     = ls_we;
        m_wdata  = ls_wdata;
        m_streak = if_req ? ((m_streak < 15) ? m_streak + 1 : 15) : 0;
        m_age    = 1;
        m_known  = 1'b0;
      end else if (if_req) begin
        m_owner  = 1;
        m_addr   = if_addr;
        m_we     = '0;
        m_wdata  = '0;
        m_streak = 0;
        m_age    = 1;
        m_known  = 1'b0;
      end else begin
        m_streak = 0;
      end
    end else if (e_done) begin
      m_owner = 0;
    end else begin
      m_age++;
    end
  end

  bit got_if, got_ls;

  initial begin
    rstn = 1'b0;
    if_req = 0; if_addr = 0; ls_req = 0; ls_addr = 0; ls_we = 0; ls_wdata = 0;
    mem_ready = 0; mem_rdata = 0;

    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("rst_mem_req", {31'd0, mem_req}, 32'd0);
    checkOutput("rst_mem_addr", mem_addr, 32'd0);
    checkOutput("rst_cpu_wait", {31'd0, cpu_wait}, 32'd0);

    // fetch only, zero-wait memory
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    rstn = 1'b1;
    applyStimulus(1, 32'h100, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("if_c0_mem_req", {31'd0, mem_req}, 32'd0);
    checkOutput("if_c0_cpu_wait", {31'd0, cpu_wait}, 32'd1);
    applyStimulus(1, 32'h100, 0, 0, 0, 0, 1, 32'h0000_0013);
    @(negedge clk);
    checkOutput("if_c1_mem_req", {31'd0, mem_req}, 32'd1);
    checkOutput("if_c1_mem_addr", mem_addr, 32'h100);
    checkOutput("if_c1_mem_we", {28'd0, mem_we}, 32'd0);
    checkOutput("if_c1_ack", {31'd0, if_ack}, 32'd1);
    checkOutput("if_c1_rdata", if_rdata, 32'h0000_0013);
    checkOutput("if_c1_cpu_wait", {31'd0, cpu_wait}, 32'd0);

    // partial store
    applyStimulus(0, 0, 1, 32'h2000, 4'b0011, 32'hA5A5_1234, 0, 0);
    applyStimulus(0, 0, 1, 32'h2000, 4'b0011, 32'hA5A5_1234, 1, 0);
    @(negedge clk);
    checkOutput("st_mem_addr", mem_addr, 32'h2000);
    checkOutput("st_mem_we", {28'd0, mem_we}, 32'h3);
    checkOutput("st_mem_wdata", mem_wdata, 32'hA5A5_1234);
    checkOutput("st_ls_ack", {31'd0, ls_ack}, 32'd1);
    checkOutput("st_ls_rdata", ls_rdata, 32'd0);

    // both ports held: LS x4, then the starving fetch, then LS again
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1, 32'h40, 1, 32'h3000, 0, 0, 0, 0);
      applyStimulus(1, 32'h40, 1, 32'h3000, 0, 0, 1, 32'h1111);
      @(negedge clk);
      checkOutput($sformatf("order%0d_if_ack", i), {31'd0, if_ack}, (i == 4) ? 32'd1 : 32'd0);
      checkOutput($sformatf("order%0d_ls_ack", i), {31'd0, ls_ack}, (i == 4) ? 32'd0 : 32'd1);
    end

    // timeout without mem_ready, then mem_ready exactly on the timeout cycle
    for (int run = 0; run < 2; run++) begin
      applyStimulus(0, 0, 1, 32'h3000, 0, 0, 0, 32'h5A5A_0F0F);
      for (int c = 1; c <= TIMEOUT; c++) begin
        applyStimulus(0, 0, 1, 32'h3000, 0, 0, (run == 1) && (c == TIMEOUT), 32'h5A5A_0F0F);
        @(negedge clk);
        if (c == TIMEOUT - 1) begin
          checkOutput($sformatf("to%0d_early_ack", run), {31'd0, ls_ack}, 32'd0);
        end
      end
      checkOutput($sformatf("to%0d_ls_ack", run), {31'd0, ls_ack}, 32'd1);
      checkOutput($sformatf("to%0d_ls_rdata", run), ls_rdata, (run == 1) ? 32'h5A5A_0F0F : 32'd0);
      checkOutput($sformatf("to%0d_bus_err", run), {31'd0, bus_err}, (run == 1) ? 32'd0 : 32'd1);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      checkOutput($sformatf("to%0d_mem_req_after", run), {31'd0, mem_req}, 32'd0);
      checkOutput($sformatf("to%0d_bus_err_after", run), {31'd0, bus_err}, 32'd0);
    end

    // reset in the middle of an access, then a late mem_ready
    applyStimulus(0, 0, 1, 32'h4000, 4'hF, 32'hCAFE_F00D, 0, 0);
    applyStimulus(0, 0, 1, 32'h4000, 4'hF, 32'hCAFE_F00D, 0, 0);
    applyStimulus(0, 0, 1, 32'h4000, 4'hF, 32'hCAFE_F00D, 0, 0);
    rstn = 1'b0;
    @(negedge clk);
    checkOutput("rstmid_ls_ack", {31'd0, ls_ack}, 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    rstn = 1'b1;
    @(negedge clk);
    checkOutput("rstmid_mem_req", {31'd0, mem_req}, 32'd0);
    checkOutput("rstmid_mem_addr", mem_addr, 32'd0);
    checkOutput("rstmid_mem_we", {28'd0, mem_we}, 32'd0);
    checkOutput("rstmid_mem_wdata", mem_wdata, 32'd0);

    // stray mem_ready while idle
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'hFFFF_FFFF);
    @(negedge clk);
    checkOutput("stray_if_ack", {31'd0, if_ack}, 32'd0);
    checkOutput("stray_ls_ack", {31'd0, ls_ack}, 32'd0);
    checkOutput("stray_cpu_wait", {31'd0, cpu_wait}, 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("stray_mem_req", {31'd0, mem_req}, 32'd0);

    // randomized traffic; the negedge model checks every cycle
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      got_if = if_ack;
      got_ls = ls_ack;
      @(posedge clk);
      #1;
      if (!rstn) rstn = 1'b1;
      else if ($urandom_range(0, 199) == 0) rstn = 1'b0;
      if (!if_req) begin
        if ($urandom_range(0, 1) == 1) begin
          if_req  = 1'b1;
          if_addr = $urandom;
        end
      end else if (got_if) begin
        if ($urandom_range(0, 1) == 1) if_req = 1'b0;
        else if_addr = $urandom;
      end
      if (!ls_req) begin
        if ($urandom_range(0, 1) == 1) begin
          ls_req   = 1'b1;
          ls_addr  = $urandom;
          ls_we    = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
          ls_wdata = $urandom;
        end
      end else if (got_ls) begin
        if ($urandom_range(0, 1) == 1) begin
          ls_req = 1'b0;
        end else begin
          ls_addr  = $urandom;
          ls_we    = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
          ls_wdata = $urandom;
        end
      end
      mem_ready = mem_req ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0);
      mem_rdata = $urandom;
    end

    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-ported SoC memory between the core's instruction-fetch port and load/store port, so the core can run from a unified instruction/data RAM. The block sits between the core's fetch and LSU memory interfaces and the memory/bus slave. It grants one outstanding access at a time, with data priority and an instruction anti-starvation guard. It produces the core stall (`cpu_wait`) and detects memory timeouts.

## Interface
- `STARVE_MAX`, 4: max consecutive LS grants while an IF request waits (1..15)
- `TIMEOUT`, 255: cycles in BUSY without `mem_ready` before abort (1..255)
- `clk` in 1: sole clock, rising edge
- `rstn` in 1: reset is synchronous and active-low
- `if_req` in 1: fetch request, held until `if_ack`
- `if_addr` in 32: fetch address, stable while `if_req`
- `if_rdata` out 32: fetch data, valid with `if_ack`
- `if_ack` out 1: fetch completion strobe
- `ls_req` in 1: load/store request, held until `ls_ack`
- `ls_addr` in 32: data address
- `ls_we` in 4: byte write enables; 0 = load
- `ls_wdata` in 32: store data
- `ls_rdata` out 32: load data, valid with `ls_ack`
- `ls_ack` out 1: load/store completion strobe
- `mem_req` out 1: memory request, registered
- `mem_addr` out 32: registered address
- `mem_we` out 4: registered byte enables
- `mem_wdata` out 32: registered write data
- `mem_rdata` in 32: memory read data, valid with `mem_ready`
- `mem_ready` in 1: memory completion, 1-cycle pulse
- `cpu_wait` out 1: core stall
- `bus_err` out 1: timeout pulse

## Operation
- FSM states: IDLE, BUSY_IF, BUSY_LS.
- **IDLE:** grant LS if `ls_req && (!if_req || streak < STARVE_MAX)`; else grant IF if `if_req`; else stay. On a grant, register the owner's addr/we/wdata onto `mem_*` and set `mem_req`=1. For IF grants, `mem_we`=0 and `mem_wdata`=0.
- **BUSY_x:** hold `mem_*` stable. On `mem_ready`:
  - `x_ack`=1 (combinational, same cycle).
  - `x_rdata`=`mem_rdata` passthrough.
  - Next state IDLE, `mem_req`←0.
- `mem_ready` in IDLE is ignored.
- **Streak counter (4 b):**
  - Increments on an LS grant while `if_req`=1, saturating at 15.
  - Clears on an IF grant, and in any IDLE cycle with `if_req`=0.
- **Timeout counter (8 b):**
  - Clears on every grant and increments each BUSY cycle.
  - If it reaches TIMEOUT with no `mem_ready`: owner ack=1, owner rdata=0, `bus_err`=1 for that cycle, `mem_req`←0, next state IDLE.
- `mem_ready` and timeout in the same cycle: `mem_ready` wins, no `bus_err`.
- `if_rdata`/`ls_rdata` are 0 when the respective ack is 0.
- `cpu_wait` = `(if_req && !if_ack) || (ls_req && !ls_ack)`.
- The requester deasserts or changes its request in the cycle after ack. A request still asserted in IDLE is treated as a new access.

## Timing
- **Reset (`rstn`=0 at edge):**
  - State IDLE; streak and timeout counters 0.
  - `mem_req`/`mem_addr`/`mem_we`/`mem_wdata` = 0.
  - While `rstn`=0, `if_ack`/`ls_ack`/`bus_err`/`if_rdata`/`ls_rdata` = 0.
- Reset mid-transaction abandons the access with no ack. The memory must tolerate `mem_req` dropping before `mem_ready`.
- **Latency:** request seen in IDLE at cycle 0 → `mem_req`=1 from cycle 1 → ack in the same cycle as `mem_ready` (cycle k) → IDLE at k+1.
- Minimum access: 2 cycles from request to ack with a 0-wait memory (`mem_ready` in cycle 1). Back-to-back accesses cost one IDLE cycle between them.
- A timeout ack arrives at cycle TIMEOUT after the grant.
- Simultaneous IF+LS requests in IDLE: LS wins unless streak ≥ STARVE_MAX.

## Structure
- Shared package `soc_bus_pkg` holds:
  - the `arb_state_t` enum (IDLE, BUSY_IF, BUSY_LS);
  - the `ARB_ERR_RDATA` (32'h0) constant;
  - the STARVE_MAX/TIMEOUT defaults, reused by future bus slaves.
- One sub-module, `arb_timeout_cnt` (clear/enable/expired), reused by the future peripheral bridge. The grant logic stays inline.

## Test plan
- **IF only**, memory with 0-wait: `if_req`=1, addr 0x100 → `mem_req` at cycle 1 with `mem_addr`=0x100 and `mem_we`=0; `if_ack`=1 with `if_rdata`=`mem_rdata` (0x00000013) in the `mem_ready` cycle; `cpu_wait` 1→0.
- **Store**: `ls_req`, `ls_we`=4'b0011, addr 0x2000, wdata 0xA5A5_1234 → `mem_we`=0011, `mem_wdata`=0xA5A51234; `ls_ack` with `mem_ready`; `ls_rdata`=0.
- **Simultaneous IF+LS**, both held continuously, STARVE_MAX=4 → grant order LS,LS,LS,LS,IF,LS…; streak clears after the IF grant.
- **Timeout**, TIMEOUT=8, `mem_ready` never asserted → at cycle 8 after grant: `ls_ack`=1, `ls_rdata`=0, `bus_err`=1 for one cycle, `mem_req`=0 at the next cycle. Repeat with `mem_ready` on cycle 8 → no `bus_err`.
- **Reset mid-BUSY**: `rstn`=0 for one cycle during an LS access with 3 wait states → no ack, all `mem_*` 0 next cycle; a later `mem_ready` in IDLE is ignored.
- **Stray `mem_ready`** in IDLE with no requests → no ack, no state change, `cpu_wait`=0.
